data_packer_stream: RTL and testbench

Width-up converter between a narrow producer stream and a wide consumer stream in the dnnweaver datapath, e.g. 64-bit read-buffer words into 128/256-bit PE or memory-write words.
- Successor to the single-ratio packer. Adds full valid/ready backpressure on both sides, arbitrary integer pack ratios, and a registered output stage.
- Adds a last-beat flush: partial words are zero-padded and tagged with a beat count and a last flag.

---
 rtl/data_packer_stream_pkg.sv | 24 ++
 rtl/data_packer_out_reg.sv | 35 +++
 rtl/data_packer_stream.sv | 90 +++++++++
 tb/tb_data_packer_stream.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_packer_stream_pkg.sv
// Shared helpers for the stream packer/unpacker family.
// Provides clog2 and the width-multiple legality check.
package data_packer_stream_pkg;

   // Bits needed to index v entries (0 for v<=1).
   function automatic int unsigned f_clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned p = 1; p < v; p = p << 1) begin
         r = r + 1;
      end
      return r;
   endfunction

   // True when wide is a non-zero integer multiple of narrow.
   function automatic bit f_width_multiple(
      input int unsigned wide,
      input int unsigned narrow
   );
      return (narrow != 0) && (wide >= narrow) &&
             ((wide % narrow) == 0);
   endfunction

endpackage

// File: rtl/data_packer_out_reg.sv
// One-entry valid/ready holding register for a stream payload.
// Ports: i_load/i_data fill, i_ready drains, o_valid/o_data hold.
module data_packer_out_reg #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_load,
   input  logic [W-1:0] i_data,
   input  logic         i_ready,
   output logic         o_valid,
   output logic [W-1:0] o_data
);

   logic         r_valid;
   logic [W-1:0] r_data;

   // Load wins over drain: a drain and reload in the same
   // cycle keeps the entry full with the new payload.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/data_packer_stream.sv
// Width-up stream packer: NUM_BEATS narrow beats -> one wide word.
// s_write_* narrow input, m_write_* wide output with count/last.
module data_packer_stream
   import data_packer_stream_pkg::*;
#(
   parameter  int unsigned IN_WIDTH  = 64,
   parameter  int unsigned OUT_WIDTH = 128,
   parameter  int unsigned OP_WIDTH  = 16,
   localparam int unsigned NUM_BEATS = OUT_WIDTH / IN_WIDTH,
   localparam int unsigned COUNT_W   = f_clog2(NUM_BEATS) + 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 s_write_req,
   output logic                 s_write_ready,
   input  logic [IN_WIDTH-1:0]  s_write_data,
   input  logic                 s_write_last,
   output logic                 m_write_req,
   input  logic                 m_write_ready,
   output logic [OUT_WIDTH-1:0] m_write_data,
   output logic [COUNT_W-1:0]   m_write_count,
   output logic                 m_write_last
);

   localparam int unsigned PAY_W = OUT_WIDTH + COUNT_W + 1;

   if (!f_width_multiple(OUT_WIDTH, IN_WIDTH) ||
       !f_width_multiple(IN_WIDTH, OP_WIDTH)) begin : g_bad_cfg
      $fatal(1, "data_packer_stream: illegal width parameters");
   end

   logic [OUT_WIDTH-1:0] r_acc;
   logic [COUNT_W-1:0]   r_cnt;
   logic                 w_s_fire;
   logic                 w_complete;
   logic                 w_m_valid;
   logic [OUT_WIDTH-1:0] w_merged;
   logic [PAY_W-1:0]     w_pay_in;
   logic [PAY_W-1:0]     w_pay_out;

   // Accept only if the output slot is free or draining now.
   assign s_write_ready = !w_m_valid | m_write_ready;
   assign w_s_fire      = s_write_req & s_write_ready;
   assign w_complete    =
      (r_cnt == COUNT_W'(NUM_BEATS - 1)) | s_write_last;

   // Slots above r_cnt are still zero in r_acc, which gives
   // the zero padding of a short last word for free.
   always_comb begin
      w_merged = r_acc;
      for (int i = 0; i < NUM_BEATS; i++) begin
         if (r_cnt == COUNT_W'(i)) begin
            w_merged[i*IN_WIDTH +: IN_WIDTH] = s_write_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cnt <= '0;
         r_acc <= '0;
      end else if (w_s_fire) begin
         if (w_complete) begin
            r_cnt <= '0;
            r_acc <= '0;
         end else begin
            r_cnt <= r_cnt + COUNT_W'(1);
            r_acc <= w_merged;
         end
      end
   end

   assign w_pay_in = {w_merged, r_cnt + COUNT_W'(1), s_write_last};

   data_packer_out_reg #(
      .W (PAY_W)
   ) u_out_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .i_load  (w_s_fire & w_complete),
      .i_data  (w_pay_in),
      .i_ready (m_write_ready),
      .o_valid (w_m_valid),
      .o_data  (w_pay_out)
   );

   assign m_write_req = w_m_valid;
   assign {m_write_data, m_write_count, m_write_last} = w_pay_out;

endmodule

// File: tb/tb_data_packer_stream.sv
// Directed and random bench for data_packer_stream.
// Three instances: 64->128, 16->64, 64->64.
module tb_data_packer_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   // A: 64 -> 128
   logic         a_s_req, a_s_ready, a_s_last;
   logic [63:0]  a_s_data;
   logic         a_m_req, a_m_ready, a_m_last;
   logic [127:0] a_m_data;
   logic [1:0]   a_m_count;

   // B: 16 -> 64
   logic         b_s_req, b_s_ready, b_s_last;
   logic [15:0]  b_s_data;
   logic         b_m_req, b_m_ready, b_m_last;
   logic [63:0]  b_m_data;
   logic [2:0]   b_m_count;

   // C: 64 -> 64
   logic         c_s_req, c_s_ready, c_s_last;
   logic [63:0]  c_s_data;
   logic         c_m_req, c_m_ready, c_m_last;
   logic [63:0]  c_m_data;
   logic [0:0]   c_m_count;

   data_packer_stream #(
      .IN_WIDTH  (64),
      .OUT_WIDTH (128),
      .OP_WIDTH  (16)
   ) u_a (
      .clk           (clk),
      .reset_n       (reset_n),
      .s_write_req   (a_s_req),
      .s_write_ready (a_s_ready),
      .s_write_data  (a_s_data),
      .s_write_last  (a_s_last),
      .m_write_req   (a_m_req),
      .m_write_ready (a_m_ready),
      .m_write_data  (a_m_data),
      .m_write_count (a_m_count),
      .m_write_last  (a_m_last)
   );

   data_packer_stream #(
      .IN_WIDTH  (16),
      .OUT_WIDTH (64),
      .OP_WIDTH  (16)
   ) u_b (
      .clk           (clk),
      .reset_n       (reset_n),
      .s_write_req   (b_s_req),
      .s_write_ready (b_s_ready),
      .s_write_data  (b_s_data),
      .s_write_last  (b_s_last),
      .m_write_req   (b_m_req),
      .m_write_ready (b_m_ready),
      .m_write_data  (b_m_data),
      .m_write_count (b_m_count),
      .m_write_last  (b_m_last)
   );

   data_packer_stream #(
      .IN_WIDTH  (64),
      .OUT_WIDTH (64),
      .OP_WIDTH  (16)
   ) u_c (
      .clk           (clk),
      .reset_n       (reset_n),
      .s_write_req   (c_s_req),
      .s_write_ready (c_s_ready),
      .s_write_data  (c_s_data),
      .s_write_last  (c_s_last),
      .m_write_req   (c_m_req),
      .m_write_ready (c_m_ready),
      .m_write_data  (c_m_data),
      .m_write_count (c_m_count),
      .m_write_last  (c_m_last)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      a_m_ready = 1'b0;
      a_s_req   = 1'b1;
      a_s_data  = 64'hDEAD;
      tick();
      tick();
      checks++;
      if (a_m_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_m_req: got %0b want 0", a_m_req);
      end
      checks++;
      if (a_m_data !== 128'h0) begin
         errors++;
         $display("FAIL reset_m_data: got %h want 0", a_m_data);
      end
      checks++;
      if (a_m_count !== 2'd0 || a_m_last !== 1'b0) begin
         errors++;
         $display("FAIL reset_cnt_last: got %0d/%0b want 0/0",
                  a_m_count, a_m_last);
      end
      checks++;
      if (b_m_req !== 1'b0 || c_m_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_bc_req: got %0b/%0b want 0/0",
                  b_m_req, c_m_req);
      end
      reset_n = 1'b1;
      a_s_req = 1'b0;
      tick();
      checks++;
      if (a_s_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_s_ready: got %0b want 1", a_s_ready);
      end
      checks++;
      if (b_s_ready !== 1'b1 || c_s_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_bc_ready: got %0b/%0b want 1/1",
                  b_s_ready, c_s_ready);
      end
      a_m_ready = 1'b1;
   endtask

   task automatic test_back_to_back();
      a_m_ready = 1'b1;
      a_s_last  = 1'b0;
      a_s_req   = 1'b1;
      a_s_data  = 64'hA;
      #1;
      checks++;
      if (a_s_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ready0: got %0b want 1", a_s_ready);
      end
      tick();
      checks++;
      if (a_m_req !== 1'b0) begin
         errors++;
         $display("FAIL b2b_early_req: got %0b want 0", a_m_req);
      end
      a_s_data = 64'hB;
      tick();
      checks++;
      if (a_m_req !== 1'b1 || a_s_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_req_ready: got %0b/%0b want 1/1",
                  a_m_req, a_s_ready);
      end
      checks++;
      if (a_m_data !== {64'hB, 64'hA}) begin
         errors++;
         $display("FAIL b2b_data: got %h want %h",
                  a_m_data, {64'hB, 64'hA});
      end
      checks++;
      if (a_m_count !== 2'd2 || a_m_last !== 1'b0) begin
         errors++;
         $display("FAIL b2b_cnt_last: got %0d/%0b want 2/0",
                  a_m_count, a_m_last);
      end
      a_s_req = 1'b0;
      tick();
      checks++;
      if (a_m_req !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain: got %0b want 0", a_m_req);
      end
   endtask

   task automatic test_last_flush();
      b_m_ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         b_s_req  = 1'b1;
         b_s_data = 16'(i);
         b_s_last = (i == 3);
         tick();
      end
      checks++;
      if (b_m_req !== 1'b1 || b_m_data !== 64'h0000_0003_0002_0001) begin
         errors++;
         $display("FAIL flush_data: got %0b/%h want 1/%h",
                  b_m_req, b_m_data, 64'h0000_0003_0002_0001);
      end
      checks++;
      if (b_m_count !== 3'd3 || b_m_last !== 1'b1) begin
         errors++;
         $display("FAIL flush_cnt_last: got %0d/%0b want 3/1",
                  b_m_count, b_m_last);
      end
      b_s_data = 16'h7;
      b_s_last = 1'b1;
      tick();
      checks++;
      if (b_m_data !== 64'h7 || b_m_count !== 3'd1 ||
          b_m_last !== 1'b1 || b_m_req !== 1'b1) begin
         errors++;
         $display("FAIL flush_restart: got %h/%0d/%0b want 7/1/1",
                  b_m_data, b_m_count, b_m_last);
      end
      b_s_req  = 1'b0;
      b_s_last = 1'b0;
      tick();
      checks++;
      if (b_m_req !== 1'b0) begin
         errors++;
         $display("FAIL flush_drain: got %0b want 0", b_m_req);
      end
   endtask

   task automatic test_backpressure();
      logic [63:0]  beats [4];
      logic [127:0] got [$];
      int           idx;
      bit           sf;
      bit           mf;
      beats[0] = 64'h11;
      beats[1] = 64'h22;
      beats[2] = 64'h33;
      beats[3] = 64'h44;
      idx = 0;
      a_s_last = 1'b0;
      for (int cyc = 0; cyc < 40 && (idx < 4 || a_m_req); cyc++) begin
         a_m_ready = (cyc >= 6);
         a_s_req   = (idx < 4);
         a_s_data  = (idx < 4) ? beats[idx] : 64'h0;
         #1;
         if (cyc == 1) begin
            checks++;
            if (a_s_ready !== 1'b1) begin
               errors++;
               $display("FAIL bp_ready_before: got %0b want 1",
                        a_s_ready);
            end
         end
         if (cyc == 3 || cyc == 5) begin
            checks++;
            if (a_s_ready !== 1'b0 || a_m_req !== 1'b1 || idx != 2) begin
               errors++;
               $display("FAIL bp_hold_ctl: got rdy=%0b req=%0b idx=%0d want 0/1/2",
                        a_s_ready, a_m_req, idx);
            end
            checks++;
            if (a_m_data !== {64'h22, 64'h11} || a_m_count !== 2'd2) begin
               errors++;
               $display("FAIL bp_hold_data: got %h/%0d want %h/2",
                        a_m_data, a_m_count, {64'h22, 64'h11});
            end
         end
         sf = a_s_req & a_s_ready;
         mf = a_m_req & a_m_ready;
         if (mf) got.push_back(a_m_data);
         tick();
         if (sf) idx++;
      end
      a_s_req   = 1'b0;
      a_m_ready = 1'b1;
      checks++;
      if (got.size() != 2 || idx != 4) begin
         errors++;
         $display("FAIL bp_counts: got words=%0d beats=%0d want 2/4",
                  got.size(), idx);
      end
      if (got.size() >= 1) begin
         checks++;
         if (got[0] !== {64'h22, 64'h11}) begin
            errors++;
            $display("FAIL bp_word0: got %h want %h",
                     got[0], {64'h22, 64'h11});
         end
      end
      if (got.size() >= 2) begin
         checks++;
         if (got[1] !== {64'h44, 64'h33}) begin
            errors++;
            $display("FAIL bp_word1: got %h want %h",
                     got[1], {64'h44, 64'h33});
         end
      end
   endtask

   task automatic test_stream();
      localparam int N = 1000;
      logic [63:0]  bd [$];
      bit           bl [$];
      logic [127:0] ed [$];
      logic [1:0]   ec [$];
      bit           el [$];
      logic [127:0] w;
      logic [127:0] held;
      int           slot;
      int           idx;
      int           nrx;
      int           cyc;
      bit           sf;
      bit           mf;
      bit           hold;
      for (int i = 0; i < N; i++) begin
         bd.push_back({$urandom(), $urandom()});
         bl.push_back((i == N - 1) || ($urandom_range(0, 4) == 0));
      end
      w = '0;
      slot = 0;
      for (int i = 0; i < N; i++) begin
         w[slot*64 +: 64] = bd[i];
         if (slot == 1 || bl[i]) begin
            ed.push_back(w);
            ec.push_back(2'(slot + 1));
            el.push_back(bl[i]);
            w = '0;
            slot = 0;
         end else begin
            slot++;
         end
      end
      idx  = 0;
      nrx  = 0;
      cyc  = 0;
      hold = 1'b0;
      held = '0;
      while (nrx < ed.size() && cyc < 20000) begin
         a_s_req   = (idx < N) && ($urandom_range(0, 3) != 0);
         a_s_data  = (idx < N) ? bd[idx] : 64'h0;
         a_s_last  = (idx < N) ? bl[idx] : 1'b0;
         a_m_ready = ($urandom_range(0, 1) == 1);
         #1;
         if (hold) begin
            checks++;
            if (a_m_req !== 1'b1 || a_m_data !== held) begin
               errors++;
               $display("FAIL stream_hold: got %0b/%h want 1/%h",
                        a_m_req, a_m_data, held);
            end
         end
         sf = a_s_req & a_s_ready;
         mf = a_m_req & a_m_ready;
         hold = a_m_req & !a_m_ready;
         held = a_m_data;
         if (mf) begin
            checks++;
            if ({a_m_data, a_m_count, a_m_last} !==
                {ed[nrx], ec[nrx], el[nrx]}) begin
               errors++;
               $display("FAIL stream_word%0d: got %h/%0d/%0b want %h/%0d/%0b",
                        nrx, a_m_data, a_m_count, a_m_last,
                        ed[nrx], ec[nrx], el[nrx]);
            end
            nrx++;
         end
         tick();
         if (sf) idx++;
         cyc++;
      end
      a_s_req   = 1'b0;
      a_s_last  = 1'b0;
      a_m_ready = 1'b1;
      tick();
      checks++;
      if (nrx != ed.size() || idx != N || a_m_req !== 1'b0) begin
         errors++;
         $display("FAIL stream_totals: got words=%0d beats=%0d req=%0b want %0d/%0d/0",
                  nrx, idx, a_m_req, ed.size(), N);
      end
   endtask

   task automatic test_reset_mid();
      a_m_ready = 1'b1;
      a_s_last  = 1'b0;
      a_s_req   = 1'b1;
      a_s_data  = 64'h9;
      tick();
      reset_n = 1'b0;
      a_s_req = 1'b0;
      tick();
      reset_n = 1'b1;
      checks++;
      if (a_m_req !== 1'b0 || a_s_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_ctl: got req=%0b rdy=%0b want 0/1",
                  a_m_req, a_s_ready);
      end
      a_s_last = 1'b1;
      tick();
      checks++;
      if (a_m_req !== 1'b0) begin
         errors++;
         $display("FAIL last_no_req: got %0b want 0", a_m_req);
      end
      a_s_last = 1'b0;
      a_s_req  = 1'b1;
      a_s_data = 64'h5;
      tick();
      checks++;
      if (a_m_req !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_early: got %0b want 0", a_m_req);
      end
      a_s_data = 64'h6;
      tick();
      checks++;
      if (a_m_req !== 1'b1 || a_m_data !== {64'h6, 64'h5} ||
          a_m_count !== 2'd2 || a_m_last !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_word: got %0b/%h/%0d/%0b want 1/%h/2/0",
                  a_m_req, a_m_data, a_m_count, a_m_last,
                  {64'h6, 64'h5});
      end
      a_s_req = 1'b0;
      tick();
   endtask

   task automatic test_passthrough();
      c_m_ready = 1'b1;
      c_s_req   = 1'b1;
      c_s_data  = 64'hC;
      c_s_last  = 1'b0;
      tick();
      checks++;
      if (c_m_req !== 1'b1 || c_m_data !== 64'hC ||
          c_m_count !== 1'b1 || c_m_last !== 1'b0) begin
         errors++;
         $display("FAIL pass_c: got %0b/%h/%0d/%0b want 1/c/1/0",
                  c_m_req, c_m_data, c_m_count, c_m_last);
      end
      c_s_data = 64'hD;
      c_s_last = 1'b1;
      tick();
      checks++;
      if (c_m_req !== 1'b1 || c_m_data !== 64'hD ||
          c_m_count !== 1'b1 || c_m_last !== 1'b1) begin
         errors++;
         $display("FAIL pass_d: got %0b/%h/%0d/%0b want 1/d/1/1",
                  c_m_req, c_m_data, c_m_count, c_m_last);
      end
      c_s_req  = 1'b0;
      c_s_last = 1'b0;
      tick();
      checks++;
      if (c_m_req !== 1'b0) begin
         errors++;
         $display("FAIL pass_drain: got %0b want 0", c_m_req);
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      a_s_req   = 1'b0;
      a_s_last  = 1'b0;
      a_s_data  = '0;
      a_m_ready = 1'b1;
      b_s_req   = 1'b0;
      b_s_last  = 1'b0;
      b_s_data  = '0;
      b_m_ready = 1'b1;
      c_s_req   = 1'b0;
      c_s_last  = 1'b0;
      c_s_data  = '0;
      c_m_ready = 1'b1;
      #1;
      test_reset();
      test_back_to_back();
      test_last_flush();
      test_backpressure();
      test_stream();
      test_reset_mid();
      test_passthrough();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
